// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline.
// It detects load-use hazards and inserts bubbles. It redirects the PC on
// branches resolved taken in EX. It freezes the pipeline while the data
// memory is busy. It also keeps saturating stall and flush statistics.
module pipeline_hazard_ctrl #(
   parameter int REG_W        = 5,
   parameter int LOAD_BUBBLES = 1,
   parameter int MAX_WAIT     = 15,
   parameter int CNT_W        = 16
) (
   input  logic             CLK,
   input  logic             Reset_n,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rt,
   input  logic             ex_mem_read,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_hold,
   output logic             pc_sel,
   output logic             if_id_hold,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             pipe_freeze,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {RUN, LOAD_STALL, MEM_WAIT} state_t;

   localparam logic [CNT_W-1:0] cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t     state, state_nxt;
   logic [2:0] bubble_cnt, bubble_nxt;
   logic [7:0] wait_cnt, wait_nxt;
   logic       timeout_set;
   logic       hazard;
   logic       mem_stall;

   // A load in EX produces a register that the instruction in ID still needs.
   assign hazard = ex_mem_read && (ex_rd != '0) &&
                   ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
   // The MEM stage wants data and the memory cannot deliver it this cycle.
   assign mem_stall = mem_req && !mem_ready;

   // Next-state and control outputs. Outputs act in the same cycle and are
   // held at zero while reset is asserted.
   always_comb begin
      // NOTE: every signal gets a default before the case, so no path can
      // leave one unassigned and infer a latch.
      state_nxt   = state;
      bubble_nxt  = bubble_cnt;
      wait_nxt    = wait_cnt;
      timeout_set = 1'b0;
      pc_hold     = 1'b0;
      pc_sel      = 1'b0;
      if_id_hold  = 1'b0;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      pipe_freeze = 1'b0;
      if (Reset_n) begin
         case (state)
            RUN, LOAD_STALL: begin
               if (mem_stall) begin
                  // A memory wait wins. Bubbles still pending are dropped
                  // because the load has already left EX.
                  pc_hold     = 1'b1;
                  if_id_hold  = 1'b1;
                  pipe_freeze = 1'b1;
                  state_nxt   = MEM_WAIT;
                  bubble_nxt  = 3'd0;
                  wait_nxt    = 8'd1;
                  timeout_set = (MAX_WAIT <= 1);
               end else if (state == LOAD_STALL) begin
                  pc_hold     = 1'b1;
                  if_id_hold  = 1'b1;
                  id_ex_flush = 1'b1;
                  if (bubble_cnt <= 3'd1) begin
                     state_nxt  = RUN;
                     bubble_nxt = 3'd0;
                  end else begin
                     bubble_nxt = bubble_cnt - 3'd1;
                  end
               end else if (ex_branch_taken) begin
                  // The instruction in ID is flushed, so any hazard it
                  // carries is irrelevant.
                  pc_sel      = 1'b1;
                  if_id_flush = 1'b1;
                  id_ex_flush = 1'b1;
               end else if (hazard) begin
                  pc_hold     = 1'b1;
                  if_id_hold  = 1'b1;
                  id_ex_flush = 1'b1;
                  if (LOAD_BUBBLES > 1) begin
                     state_nxt  = LOAD_STALL;
                     bubble_nxt = 3'(LOAD_BUBBLES - 1);
                  end
               end
            end
            MEM_WAIT: begin
               // EX is frozen, so a taken branch is ignored here. The branch
               // is seen again once the pipeline is released.
               if (mem_ready) begin
                  state_nxt = RUN;
                  wait_nxt  = 8'd0;
               end else begin
                  pc_hold     = 1'b1;
                  if_id_hold  = 1'b1;
                  pipe_freeze = 1'b1;
                  wait_nxt    = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
                  timeout_set = (wait_nxt >= 8'(MAX_WAIT));
               end
            end
            default: state_nxt = RUN;
         endcase
      end
   end

   // State register and internal bubble and wait counters.
   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         state      <= RUN;
         bubble_cnt <= 3'd0;
         wait_cnt   <= 8'd0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments, so all
         // registers update together from values taken before the edge.
         state      <= state_nxt;
         bubble_cnt <= bubble_nxt;
         wait_cnt   <= wait_nxt;
      end
   end

   // Saturating statistics counters and the sticky timeout flag.
   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         stall_cnt   <= '0;
         flush_cnt   <= '0;
         mem_timeout <= 1'b0;
      end else begin
         if (pc_hold && (stall_cnt != '1)) stall_cnt <= stall_cnt + cnt_one;
         if (pc_sel && (flush_cnt != '1))  flush_cnt <= flush_cnt + cnt_one;
         if (timeout_set)                  mem_timeout <= 1'b1;
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl. A driver applies directed and
// random stimulus. A cycle-level reference model turns each cycle's inputs
// into the outputs expected for that cycle and queues them. A monitor
// compares the queued values against the DUT on every falling edge.
module tb_pipeline_hazard_ctrl;

   localparam int REG_W        = 5;
   localparam int LOAD_BUBBLES = 2;
   localparam int MAX_WAIT     = 3;
   localparam int CNT_W        = 4;
   localparam int CNT_MAX      = (1 << CNT_W) - 1;

   logic             CLK;
   logic             Reset_n;
   logic [REG_W-1:0] id_rs, id_rt, ex_rd;
   logic             id_uses_rt, ex_mem_read, ex_branch_taken, mem_req, mem_ready;
   logic             pc_hold, pc_sel, if_id_hold, if_id_flush, id_ex_flush;
   logic             pipe_freeze, mem_timeout;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   pipeline_hazard_ctrl #(
      .REG_W(REG_W), .LOAD_BUBBLES(LOAD_BUBBLES), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)
   ) dut (
      .CLK(CLK), .Reset_n(Reset_n),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
      .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_hold(pc_hold), .pc_sel(pc_sel), .if_id_hold(if_id_hold),
      .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .pipe_freeze(pipe_freeze),
      .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   typedef struct {
      int   idx;
      logic pc_hold, pc_sel, if_id_hold, if_id_flush, id_ex_flush, pipe_freeze;
      logic timeout;
      int   stall, flush;
   } exp_t;

   exp_t q[$];
   int   n_pass  = 0;
   int   n_total = 0;
   int   cyc     = 0;

   // Reference model state, expressed as pending work rather than as FSM states.
   int m_bubbles_left = 0;  // bubbles still owed after the current one
   bit m_waiting      = 0;
   int m_wait         = 0;
   bit m_timeout      = 0;
   int m_stall        = 0;
   int m_flush        = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Produce the expected outputs for the inputs currently driven, then
   // advance the model past the coming clock edge.
   task automatic model_step(output exp_t e);
      bit hz;
      e = '{idx: cyc, default: 0};
      if (!Reset_n) begin
         m_bubbles_left = 0; m_waiting = 0; m_wait = 0;
         m_timeout = 0; m_stall = 0; m_flush = 0;
         return;
      end
      e.stall   = m_stall;
      e.flush   = m_flush;
      e.timeout = m_timeout;
      hz = ex_mem_read && (ex_rd != 0) &&
           ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
      if (m_waiting) begin
         if (mem_ready) m_waiting = 0;
         else begin
            e.pc_hold = 1; e.if_id_hold = 1; e.pipe_freeze = 1;
            if (m_wait < 255) m_wait++;
            if (m_wait >= MAX_WAIT) m_timeout = 1;
         end
      end else if (mem_req && !mem_ready) begin
         e.pc_hold = 1; e.if_id_hold = 1; e.pipe_freeze = 1;
         m_waiting = 1; m_wait = 1; m_bubbles_left = 0;
         if (m_wait >= MAX_WAIT) m_timeout = 1;
      end else if (m_bubbles_left > 0) begin
         e.pc_hold = 1; e.if_id_hold = 1; e.id_ex_flush = 1;
         m_bubbles_left--;
      end else if (ex_branch_taken) begin
         e.pc_sel = 1; e.if_id_flush = 1; e.id_ex_flush = 1;
         if (m_flush < CNT_MAX) m_flush++;
      end else if (hz) begin
         e.pc_hold = 1; e.if_id_hold = 1; e.id_ex_flush = 1;
         m_bubbles_left = LOAD_BUBBLES - 1;
      end
      if (e.pc_hold && m_stall < CNT_MAX) m_stall++;
   endtask

   // Apply one cycle of stimulus just after the rising edge and queue the expectation.
   task automatic drive(input logic rst, input logic br, input logic req, input logic rdy,
                        input logic mr, input logic [REG_W-1:0] rd,
                        input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                        input logic uses);
      exp_t e;
      @(posedge CLK);
      #1;
      Reset_n = rst; ex_branch_taken = br; mem_req = req; mem_ready = rdy;
      ex_mem_read = mr; ex_rd = rd; id_rs = rs; id_rt = rt; id_uses_rt = uses;
      model_step(e);
      q.push_back(e);
      cyc++;
   endtask

   task automatic idle();
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic reset_hostile();
      drive(0, 1, 1, 0, 1, 5, 5, 5, 1);
   endtask

   // Monitor: compare the DUT with the oldest expectation on each falling edge.
   always @(negedge CLK) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         check($sformatf("pc_hold@%0d", e.idx),     pc_hold,     e.pc_hold);
         check($sformatf("pc_sel@%0d", e.idx),      pc_sel,      e.pc_sel);
         check($sformatf("if_id_hold@%0d", e.idx),  if_id_hold,  e.if_id_hold);
         check($sformatf("if_id_flush@%0d", e.idx), if_id_flush, e.if_id_flush);
         check($sformatf("id_ex_flush@%0d", e.idx), id_ex_flush, e.id_ex_flush);
         check($sformatf("pipe_freeze@%0d", e.idx), pipe_freeze, e.pipe_freeze);
         check($sformatf("mem_timeout@%0d", e.idx), mem_timeout, e.timeout);
         check($sformatf("stall_cnt@%0d", e.idx),   stall_cnt,   e.stall[CNT_W-1:0]);
         check($sformatf("flush_cnt@%0d", e.idx),   flush_cnt,   e.flush[CNT_W-1:0]);
      end
   end

   initial begin
      Reset_n = 1; ex_branch_taken = 0; mem_req = 0; mem_ready = 0;
      ex_mem_read = 0; ex_rd = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0;
      #2 Reset_n = 0;

      // Reset overrides hostile inputs.
      reset_hostile(); #1;
      check("rst pc_sel", pc_sel, 0);
      check("rst pc_hold", pc_hold, 0);
      check("rst pipe_freeze", pipe_freeze, 0);
      check("rst stall_cnt", stall_cnt, 0);
      // The first cycle after release acts on its inputs.
      drive(1, 1, 0, 0, 0, 0, 0, 0, 0); #1;
      check("release pc_sel", pc_sel, 1);
      check("release if_id_flush", if_id_flush, 1);

      // A load-use hazard gives two bubbles.
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 1, 5, 5, 0, 0);
      drive(1, 0, 0, 0, 1, 5, 5, 0, 0);
      idle(); #1;
      check("load-use stall_cnt", stall_cnt, 2);
      check("load-use released", pc_hold, 0);
      // With ex_rd=0 there is no hazard.
      drive(1, 0, 0, 0, 1, 0, 0, 0, 0); #1;
      check("rd0 no stall", pc_hold, 0);
      // The rt source counts only when id_uses_rt is set.
      drive(1, 0, 0, 0, 1, 7, 1, 7, 0);
      drive(1, 0, 0, 0, 1, 7, 1, 7, 1);
      idle(); idle();

      // A taken branch discards a hazard in the same cycle.
      drive(1, 1, 0, 0, 1, 5, 5, 0, 0); #1;
      check("br+hz pc_sel", pc_sel, 1);
      check("br+hz pc_hold", pc_hold, 0);
      check("br+hz id_ex_flush", id_ex_flush, 1);
      idle(); #1;
      check("br+hz flush_cnt", flush_cnt, 1);

      // A four-cycle memory wait is released in the ready cycle.
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (4) drive(1, 0, 1, 0, 0, 0, 0, 0, 0);
      drive(1, 1, 1, 1, 0, 0, 0, 0, 0); #1;
      check("ready pipe_freeze", pipe_freeze, 0);
      check("ready pc_hold", pc_hold, 0);
      idle(); #1;
      check("wait stall_cnt", stall_cnt, 4);

      // A wait of two cycles does not time out. A wait of five cycles does.
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) drive(1, 0, 1, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 1, 1, 0, 0, 0, 0, 0);
      idle(); #1;
      check("short wait no timeout", mem_timeout, 0);
      for (int i = 0; i < 5; i++) begin
         drive(1, 0, 1, 0, 0, 0, 0, 0, 0); #1;
         check($sformatf("timeout rise %0d", i), mem_timeout, (i >= 3) ? 1 : 0);
      end
      drive(1, 0, 0, 1, 0, 0, 0, 0, 0);
      idle(); #1;
      check("timeout sticky", mem_timeout, 1);

      // Reset asserted in the middle of a wait.
      repeat (2) drive(1, 0, 1, 0, 0, 0, 0, 0, 0);
      reset_hostile(); #1;
      check("midwait rst pc_hold", pc_hold, 0);
      check("midwait rst pipe_freeze", pipe_freeze, 0);
      check("midwait rst mem_timeout", mem_timeout, 0);
      idle();

      // The flush counter saturates at all-ones.
      repeat (20) drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
      idle(); #1;
      check("flush_cnt saturates", flush_cnt, CNT_MAX);

      // Random traffic with small register ranges so that hazards are frequent.
      for (int i = 0; i < 800; i++) begin
         drive(logic'($urandom_range(0, 99) != 0),
               logic'($urandom_range(0, 9) == 0),
               logic'($urandom_range(0, 3) == 0),
               logic'($urandom_range(0, 1)),
               logic'($urandom_range(0, 2) == 0),
               REG_W'($urandom_range(0, 3)),
               REG_W'($urandom_range(0, 3)),
               REG_W'($urandom_range(0, 3)),
               logic'($urandom_range(0, 1)));
      end

      @(negedge CLK);
      #1;
      check("scoreboard drained", q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
